// File: rtl/mem_stage.sv
// mem_stage: execute->writeback load/store stage driving a valid/ready data-memory port.
// Optional MEM_MISALIGN_CHECK_EN traps misaligned half/word accesses instead of truncating them.
package mem_stage_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
        logic        is_final;
    } ex_to_mem_s;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_write;
        logic [31:0] data;
        logic        is_final;
        logic        instr_done;
    } mem_to_wb_s;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  ex_to_mem_s  ex_to_mem,
    output logic        mem_stall,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output mem_to_wb_s  mem_to_wb,
    output logic        mem_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_e;

    state_e      state_q;
    mem_to_wb_s  wb_q;
    logic        req_q, we_q, err_q, rw_q, fin_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q, cnt_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;

    logic        is_mem, misal, issue, accept, st_done, ld_done, tmo;
    logic [1:0]  lane;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, sh, hw, ld_data;

    always_comb begin
        lane    = ex_to_mem.alu_result[1:0];
        is_mem  = ex_to_mem.valid & (ex_to_mem.mem_read | ex_to_mem.mem_write);
`ifdef MEM_MISALIGN_CHECK_EN
        misal   = (ex_to_mem.funct3[1:0] == 2'b01 & lane[0]) | (ex_to_mem.funct3[1:0] == 2'b10 & lane != 2'b00);
`else
        misal   = 1'b0;
`endif
        issue   = state_q == IDLE & is_mem & !misal;
        accept  = state_q == REQ & dmem_req_ready;
        st_done = accept & we_q;
        // rvalid may arrive together with ready, skipping WAIT_RD
        ld_done = dmem_rvalid & !we_q & (accept | state_q == WAIT_RD);
        tmo     = DMEM_TIMEOUT != 0 && state_q != IDLE && !(accept | ld_done) && cnt_q == 32'(DMEM_TIMEOUT - 1);
        be_d    = ex_to_mem.funct3[1:0] == 2'b00 ? 4'b0001 << lane :
                  ex_to_mem.funct3[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
        wdata_d = ex_to_mem.funct3[1:0] == 2'b00 ? {4{ex_to_mem.rs2_data[7:0]}} :
                  ex_to_mem.funct3[1:0] == 2'b01 ? {2{ex_to_mem.rs2_data[15:0]}} : ex_to_mem.rs2_data;
        sh      = dmem_rdata >> {lane_q, 3'b000};
        hw      = dmem_rdata >> {lane_q[1], 4'b0000};
        ld_data = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                  f3_q == 3'b100 ? {24'd0, sh[7:0]} :
                  f3_q == 3'b001 ? {{16{hw[15]}}, hw[15:0]} :
                  f3_q == 3'b101 ? {16'd0, hw[15:0]} : dmem_rdata;
        // drops in the completing cycle so upstream advances on that edge
        mem_stall = issue | (state_q != IDLE & !(st_done | ld_done | tmo));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wb_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rw_q    <= 1'b0;
            fin_q   <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
        end else begin
            wb_q <= '0;
            if (state_q == IDLE) begin
                if (ex_to_mem.valid & !issue) begin
                    wb_q.rd         <= ex_to_mem.rd;
                    wb_q.reg_write  <= !is_mem & ex_to_mem.reg_write & (ex_to_mem.rd != 5'd0);
                    wb_q.data       <= is_mem ? 32'd0 : ex_to_mem.alu_result;
                    wb_q.is_final   <= ex_to_mem.is_final;
                    wb_q.instr_done <= 1'b1;
                    err_q           <= err_q | is_mem;
                end
                if (issue) begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    we_q    <= ex_to_mem.mem_write;
                    be_q    <= be_d;
                    addr_q  <= {ex_to_mem.alu_result[31:2], 2'b00};
                    wdata_q <= wdata_d;
                    cnt_q   <= '0;
                    rd_q    <= ex_to_mem.rd;
                    rw_q    <= ex_to_mem.reg_write & (ex_to_mem.rd != 5'd0);
                    fin_q   <= ex_to_mem.is_final;
                    f3_q    <= ex_to_mem.funct3;
                    lane_q  <= lane;
                end
            end else if (st_done | ld_done | tmo) begin
                state_q <= IDLE;
                req_q   <= 1'b0;
                cnt_q   <= '0;
                err_q   <= err_q | tmo;
                wb_q    <= '{rd: rd_q, reg_write: rw_q & ld_done, data: ld_done ? ld_data : 32'd0,
                             is_final: fin_q, instr_done: 1'b1};
            end else if (accept) begin
                state_q <= WAIT_RD;
                req_q   <= 1'b0;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign dmem_req_valid = req_q;
    assign dmem_addr      = addr_q;
    assign dmem_we        = we_q;
    assign dmem_be        = be_q;
    assign dmem_wdata     = wdata_q;
    assign mem_to_wb      = wb_q;
    assign mem_err        = err_q;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Pipeline stage between execute and writeback. Accepts one ex_to_mem_s instruction per cycle and performs load/store through a valid/ready data-memory port. Applies RV32I byte/half/word sizing, sign/zero extension and byte enables. Drives a registered mem_to_wb_s bundle to the writeback stage, and stalls upstream while a memory transaction is outstanding.

Parameters:
DMEM_TIMEOUT, 255, cycles to wait for dmem_rvalid/dmem_req_ready before aborting with mem_err; 0 disables the timeout.

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
ex_to_mem  input  ex_to_mem_s  fields: valid, alu_result[31:0] (address or ALU value), rs2_data[31:0], rd[4:0], reg_write, mem_read, mem_write, funct3[2:0], is_final
mem_stall  output  1  high = stage cannot accept; upstream holds ex_to_mem stable
dmem_req_valid  output  1  request valid
dmem_req_ready  input  1  memory accepts request
dmem_addr  output  32  word-aligned address ({alu_result[31:2],2'b00})
dmem_we  output  1  1 = store
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-shifted store data
dmem_rvalid  input  1  load data valid (one-cycle pulse)
dmem_rdata  input  32  load data word
mem_to_wb  output  mem_to_wb_s  fields: rd, reg_write, data[31:0], is_final, instr_done
mem_err  output  1  sticky: timeout (or misalign, see optional feature)

Behaviour:
- Reset: state=IDLE; mem_to_wb all fields 0; dmem_req_valid=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0; mem_stall=0; mem_err=0; timeout counter=0. Reset mid-transaction drops the access silently, with no mem_to_wb output.
- FSM states: IDLE, REQ, WAIT_RD.
- IDLE, ex_to_mem.valid and neither mem_read nor mem_write: register pass-through next cycle (data=alu_result, instr_done=1). Latency 1, no stall.
- IDLE, mem_read or mem_write: latch instruction; enter REQ with dmem_req_valid=1 (registered). mem_stall is high combinationally from this cycle until completion. mem_to_wb that cycle is a bubble (reg_write=0, instr_done=0).
- REQ: hold all dmem_* stable until dmem_req_ready.
  - Store accepted: go to IDLE; next cycle mem_to_wb has reg_write=0, instr_done=1.
  - Load accepted: go to WAIT_RD.
- WAIT_RD: on dmem_rvalid, extract and extend the data, then go to IDLE. Next cycle mem_to_wb has data=result, reg_write=latched reg_write, instr_done=1.
- Minimum load latency with ready and rvalid each asserted one cycle after request: 3 cycles to mem_to_wb.
- Data memory may assert dmem_rvalid in the same cycle as dmem_req_ready. WAIT_RD is then skipped and the load result is taken that cycle.
- Byte lane = alu_result[1:0].
  - funct3 000 LB / 100 LBU: byte at lane, sign-extend / zero-extend.
  - funct3 001 LH / 101 LHU: half at lane[1]*16, sign-extend / zero-extend.
  - funct3 010 LW: full word.
  - Stores: SB be=4'b0001<<lane, wdata=rs2[7:0] replicated to all 4 bytes; SH be=4'b0011<<lane, wdata=rs2[15:0] replicated; SW be=4'b1111.
- rd==0: reg_write forced 0 on output.
- is_final propagated unchanged.
- Timeout: counter increments in REQ/WAIT_RD, clears on progress. When it reaches DMEM_TIMEOUT: set mem_err, emit instr_done=1 with reg_write=0, return to IDLE. mem_err clears only on rst.
- dmem_rvalid outside WAIT_RD/REQ is ignored.
- ex_to_mem.valid while mem_stall is high is not consumed.

Optional Feature:
MEM_MISALIGN_CHECK_EN.
- Defined: LH/LHU/SH with lane[0]=1, or LW/SW with lane!=0, issues no dmem request. Sets mem_err and emits instr_done=1, reg_write=0 after 1 cycle.
- Undefined: no check. Misaligned half/word accesses use the lane rules above, truncated to the word (no split access).

Test Plan:
- Reset held 2 cycles during a pending load (REQ) -> all outputs 0, state IDLE, no mem_to_wb with instr_done=1 after release.
- ALU op alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle mem_to_wb.data=0x1234, rd=5, reg_write=1, instr_done=1, mem_stall never high.
- LB addr=0x103, dmem_rdata=0x80FF_0000, ready/rvalid 1 cycle after request -> dmem_addr=0x100, data=0xFFFF_FF80 three cycles after issue; LBU on the same access -> 0x0000_0080.
- SH addr=0x202, rs2=0xDEAD_BEEF, ready delayed 4 cycles -> dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF held stable all 4 cycles, mem_stall high throughout, then instr_done=1, reg_write=0.
- Load with rd=0 -> reg_write=0 at output. With DMEM_TIMEOUT=8, a load with no rvalid -> mem_err=1 after 8 wait cycles, instr_done=1, stage accepts the next instruction.
- With MEM_MISALIGN_CHECK_EN: LW addr=0x1001 -> no dmem_req_valid, mem_err=1, instr_done=1 next cycle.
